// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM with memory-ready stalls on fetch and data accesses.
// Optional addi support (opcode 001000, ADDI_WB state) is enabled by defining MC_CTRL_ADDI_EN.
module mc_main_control #(
  parameter int unsigned INIT_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] init_cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Opcode held from DECODE so MEM_ADDR can pick the access type
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   op_q <= 6'd0;
    else if (state_q == S_DECODE) op_q <= opcode;
  end

  // Post-reset idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            init_cnt_q <= '0;
    else if (state_q == S_INIT && init_cnt_q != INIT_LAST) init_cnt_q <= init_cnt_q + CNT_W'(1);
    else                                                   init_cnt_q <= '0;
  end

  assign state = 4'(state_q);

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_MEM_ADDR;
`endif
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OP_LW:   state_d = S_MEM_READ;
          OP_SW:   state_d = S_MEM_WRITE;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI: state_d = S_ADDI_WB;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule
